regincr_pipe_valrdy: RTL and testbench

Parametrised multi-stage registered incrementer with val/rdy streaming handshakes on both sides. Each pipeline stage registers its input and adds INCR. An accepted message therefore leaves the block as in_msg + NSTAGES*INCR. The block supports full backpressure and bubble collapsing. It is the generalised successor of the single-register 8-bit incrementer, intended for multi-cycle datapath tests and for latency and throughput experiments.

---
 rtl/regincr_pipe_valrdy.sv | 93 +++++++++
 tb/tb_regincr_pipe_valrdy.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regincr_pipe_valrdy.sv
// Multi-stage registered incrementer with val/rdy handshakes, bubble collapsing and full backpressure.
// Optional build macro REGINCR_PIPE_SAT_EN makes each stage's add saturate instead of wrapping.
module regincr_pipe_valrdy #(
    parameter int          W       = 8,
    parameter int          NSTAGES = 3,
    parameter int unsigned INCR    = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_val,
    output logic                               in_rdy,
    input  logic [W-1:0]                       in_msg,
    output logic                               out_val,
    input  logic                               out_rdy,
    output logic [W-1:0]                       out_msg,
    output logic [$clog2(NSTAGES+1)-1:0]       count
);

    localparam int          CW     = $clog2(NSTAGES + 1);
    localparam logic [W-1:0] INCR_W = W'(INCR);

    logic               vld_p [NSTAGES];
    logic [W-1:0]       msg_p [NSTAGES];
    logic [NSTAGES-1:0] adv;
    logic [NSTAGES-1:0] acc;
    logic               xfer_in;
    logic               xfer_out;

    function automatic logic [W-1:0] stage_add(input logic [W-1:0] a);
`ifdef REGINCR_PIPE_SAT_EN
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, INCR_W};
        return s[W] ? {W{1'b1}} : s[W-1:0];
`else
        return a + INCR_W;
`endif
    endfunction

    // Ready ripples back from the output: a stage can take a message if it is empty or is emitting.
    always_comb begin
        logic down_acc;
        adv      = '0;
        acc      = '0;
        down_acc = out_rdy;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            adv[k]   = vld_p[k] & down_acc;
            acc[k]   = ~vld_p[k] | adv[k];
            down_acc = acc[k];
        end
    end

    assign in_rdy   = acc[0];
    assign xfer_in  = in_val & acc[0];
    assign xfer_out = adv[NSTAGES-1];
    assign out_val  = vld_p[NSTAGES-1];
    assign out_msg  = msg_p[NSTAGES-1];

    // Stage 0: capture from the upstream port
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p[0] <= 1'b0;
            msg_p[0] <= '0;
        end else if (acc[0]) begin
            vld_p[0] <= in_val;
            if (in_val)
                msg_p[0] <= stage_add(in_msg);
        end
    end

    // Stages 1..NSTAGES-1: load from the previous stage when it advances
    always_ff @(posedge clk) begin
        for (int k = 1; k < NSTAGES; k++) begin
            if (reset) begin
                vld_p[k] <= 1'b0;
                msg_p[k] <= '0;
            end else if (acc[k]) begin
                vld_p[k] <= adv[k-1];
                if (adv[k-1])
                    msg_p[k] <= stage_add(msg_p[k-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (xfer_in && !xfer_out)
            count <= count + CW'(1);
        else if (!xfer_in && xfer_out)
            count <= count - CW'(1);
    end

endmodule

// File: tb/tb_regincr_pipe_valrdy.sv
// Bench for regincr_pipe_valrdy: message-position model checked every cycle plus directed literal checks.
// Build with REGINCR_PIPE_SAT_EN defined to expect the saturating variant.
module tb_regincr_pipe_valrdy;

    localparam int W    = 8;
    localparam int N    = 3;
    localparam int INCR = 1;

    logic         clk;
    logic         reset;
    logic         in_val;
    logic         in_rdy;
    logic [W-1:0] in_msg;
    logic         out_val;
    logic         out_rdy;
    logic [W-1:0] out_msg;
    logic [1:0]   count;

    int total;
    int bad;
    bit chk_en;

    // Model: each in-flight message is a (stage position, input value) pair, oldest first.
    int           pos_q[$];
    logic [W-1:0] val_q[$];

    regincr_pipe_valrdy #(.W(W), .NSTAGES(N), .INCR(INCR)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_out(input logic [W-1:0] v);
        int s;
        s = int'(v) + N * INCR;
`ifdef REGINCR_PIPE_SAT_EN
        if (s > 255) s = 255;
`endif
        return W'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_loop();
        int  np[$];
        int  lim;
        int  start;
        int  p;
        bit  ev;
        bit  er;
        bit  pop;
        forever begin
            @(negedge clk);
            ev    = (pos_q.size() > 0) && (pos_q[0] == N - 1);
            pop   = ev && (out_rdy === 1'b1);
            np    = {};
            start = pop ? 1 : 0;
            lim   = N - 1;
            for (int i = start; i < pos_q.size(); i++) begin
                p = pos_q[i] + 1;
                if (p > lim) p = lim;
                np.push_back(p);
                lim = p - 1;
            end
            er = (np.size() == 0) || (np[np.size()-1] > 0);
            if (chk_en) begin
                chk("m_out_val", {31'd0, out_val}, {31'd0, ev});
                if (ev) chk("m_out_msg", {24'd0, out_msg}, {24'd0, exp_out(val_q[0])});
                chk("m_in_rdy", {31'd0, in_rdy}, {31'd0, er});
                chk("m_count", {30'd0, count}, pos_q.size());
            end
            if (reset) begin
                pos_q  = {};
                val_q  = {};
                chk_en = 1'b1;
            end else begin
                if (pop) void'(val_q.pop_front());
                pos_q = np;
                if (in_val && er) begin
                    pos_q.push_back(0);
                    val_q.push_back(in_msg);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        int nxt;
        bit took;
        total   = 0;
        bad     = 0;
        chk_en  = 1'b0;
        reset   = 1'b1;
        in_val  = 1'b0;
        in_msg  = '0;
        out_rdy = 1'b1;
        fork
            model_loop();
        join_none

        // Reset for two cycles
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_out_val", {31'd0, out_val}, 32'd0);
        chk("rst_out_msg", {24'd0, out_msg}, 32'd0);
        chk("rst_count", {30'd0, count}, 32'd0);
        chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);

        // Single message, accepted in cycle 0, visible in cycle 3
        in_val = 1'b1;
        in_msg = 8'h10;
        tick();
        in_val = 1'b0;
        tick();
        chk("single_c2_val", {31'd0, out_val}, 32'd0);
        tick();
        chk("single_c3_val", {31'd0, out_val}, 32'd1);
        chk("single_c3_msg", {24'd0, out_msg}, 32'h13);
        chk("single_c3_cnt", {30'd0, count}, 32'd1);
        tick();
        chk("single_c4_val", {31'd0, out_val}, 32'd0);
        chk("single_c4_cnt", {30'd0, count}, 32'd0);

        // Streaming 0x00..0x09 back to back
        for (int i = 0; i < 10; i++) begin
            in_val = 1'b1;
            in_msg = W'(i);
            #1;
            chk("stream_in_rdy", {31'd0, in_rdy}, 32'd1);
            tick();
        end
        in_val = 1'b0;
        chk("stream_c10_msg", {24'd0, out_msg}, 32'h0A);
        tick();
        tick();
        chk("stream_c12_msg", {24'd0, out_msg}, 32'h0C);
        tick();
        chk("stream_drain_val", {31'd0, out_val}, 32'd0);
        chk("stream_drain_cnt", {30'd0, count}, 32'd0);

        // Backpressure: fill with out_rdy low, then release
        out_rdy = 1'b0;
        accepts = 0;
        nxt     = 0;
        for (int i = 0; i < 6; i++) begin
            in_val = 1'b1;
            in_msg = W'(nxt);
            #1;
            took = in_rdy;
            tick();
            if (took) begin
                accepts++;
                nxt++;
            end
        end
        in_msg = W'(nxt);
        #1;
        chk("bp_accepts", accepts, 32'd3);
        chk("bp_full_cnt", {30'd0, count}, 32'd3);
        chk("bp_full_rdy", {31'd0, in_rdy}, 32'd0);
        chk("bp_full_msg", {24'd0, out_msg}, 32'h03);
        out_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", {31'd0, in_rdy}, 32'd1);
        tick();
        in_val = 1'b0;
        chk("bp_second_msg", {24'd0, out_msg}, 32'h04);
        tick();
        chk("bp_third_msg", {24'd0, out_msg}, 32'h05);
        tick();
        chk("bp_fourth_msg", {24'd0, out_msg}, 32'h06);
        tick();
        chk("bp_drain_cnt", {30'd0, count}, 32'd0);

        // Wrap-around or saturation at the top of the range
        in_val = 1'b1;
        in_msg = 8'hFE;
        tick();
        in_val = 1'b0;
        tick();
        tick();
        chk("edge_val", {31'd0, out_val}, 32'd1);
`ifdef REGINCR_PIPE_SAT_EN
        chk("edge_msg", {24'd0, out_msg}, 32'hFF);
`else
        chk("edge_msg", {24'd0, out_msg}, 32'h01);
`endif
        tick();

        // Reset while two messages are stalled inside
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_msg  = 8'h20;
        tick();
        in_msg  = 8'h21;
        tick();
        in_val  = 1'b0;
        chk("midrst_pre_cnt", {30'd0, count}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_cnt", {30'd0, count}, 32'd0);
        chk("midrst_val", {31'd0, out_val}, 32'd0);
        out_rdy = 1'b1;
        in_val  = 1'b1;
        in_msg  = 8'h40;
        tick();
        in_val  = 1'b0;
        chk("midrst_c1_val", {31'd0, out_val}, 32'd0);
        tick();
        chk("midrst_c2_val", {31'd0, out_val}, 32'd0);
        tick();
        chk("midrst_c3_val", {31'd0, out_val}, 32'd1);
        chk("midrst_c3_msg", {24'd0, out_msg}, 32'h43);
        tick();
        tick();
        chk("final_cnt", {30'd0, count}, 32'd0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
